io_mailbox_responder: RTL and testbench

- Bus responder (target) for the CPU memory stage's IO bus.
- Decodes the 4 KiB IO page, runs a registered ack handshake with configurable wait states, and exposes a word-wide bidirectional mailbox to an external agent.
- The mailbox is a TX FIFO (CPU to agent) and an RX FIFO (agent to CPU), plus status and count registers.

---
 rtl/io_bus_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/io_mailbox_responder.sv | 191 +++++++++++++++++++
 tb/tb_io_mailbox_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared definitions for the IO-page mailbox responder: page constant, word offsets, FSM states.
// Offsets are word indices (byte address bits [11:2]).
package io_bus_pkg;

    localparam logic [19:0] IO_PAGE = 20'h40000;

    localparam logic [9:0] OFF_TXDATA = 10'h000;
    localparam logic [9:0] OFF_RXDATA = 10'h001;
    localparam logic [9:0] OFF_STATUS = 10'h002;
    localparam logic [9:0] OFF_COUNT  = 10'h003;
    localparam logic [9:0] OFF_IRQEN  = 10'h004;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_UNF         = 2;
    localparam int ST_OVF         = 3;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} rsp_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; push/pop take effect on the clock edge, head visible combinationally.
// Backpressure: push while full is accepted only when a pop frees the slot in the same edge.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign do_pop     = pop_i & ~empty_o;
    assign do_push    = push_i & (~full_o | do_pop);
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/io_mailbox_responder.sv
// IO-page bus target with TX/RX mailbox FIFOs; ack 1+WAIT_STATES cycles after the hit, requests 2+WAIT_STATES apart.
// Full TX drops CPU writes (OVF), empty RX reads return 0 (UNF); MAILBOX_IRQ_EN adds IRQEN and a registered irq.
module io_mailbox_responder
    import io_bus_pkg::*;
#(
    parameter logic [19:0] BASE_ADDR   = IO_PAGE,
    parameter int          WAIT_STATES = 1,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] b_addr_i,
    input  logic [31:0] b_data_i,
    input  logic        b_read_i,
    input  logic        b_write_i,
    output logic [31:0] b_data_o,
    output logic        b_ack_o,
    output logic [31:0] tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [31:0] rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        irq_o
);

    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    rsp_state_t  state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [9:0]  off_q;
    logic [31:0] wdata_q;
    logic        is_wr_q, is_rd_q;
    logic [31:0] rdata_q, rd_mux;
    logic        ovf_q, ovf_d, unf_q, unf_d;
    logic        hit, capture, commit, wr_op, rd_op;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [31:0] rx_head;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic        unused_addr;
`ifdef MAILBOX_IRQ_EN
    logic [1:0]  irqen_q;
    logic        irq_q;
`endif

    assign unused_addr = ^b_addr_i[1:0];
    assign hit = (b_read_i | b_write_i) && (b_addr_i[31:12] == BASE_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: if (hit) begin
                wait_cnt_d = '0;
                state_d    = (WAIT_STATES == 0) ? ACK : WAIT;
            end
            WAIT: if (wait_cnt_q == WAIT_LAST) state_d = ACK;
                  else wait_cnt_d = wait_cnt_q + 4'd1;
            ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        capture = (state_q == IDLE) && hit;
        commit  = (state_d == ACK);
        b_ack_o = (state_q == ACK);
    end

    // Both strobes high is a write; reads only see the pure-read case.
    assign wr_op = commit & is_wr_q;
    assign rd_op = commit & is_rd_q & ~is_wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            off_q   <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            is_rd_q <= 1'b0;
        end else if (capture) begin
            off_q   <= b_addr_i[11:2];
            wdata_q <= b_data_i;
            is_wr_q <= b_write_i;
            is_rd_q <= b_read_i;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (is_rd_q && !is_wr_q) begin
            case (off_q)
                OFF_RXDATA: rd_mux = rx_empty ? 32'h0 : rx_head;
                OFF_STATUS: begin
                    rd_mux[ST_OVF]         = ovf_q;
                    rd_mux[ST_UNF]         = unf_q;
                    rd_mux[ST_TX_FULL]     = tx_full;
                    rd_mux[ST_RX_NONEMPTY] = ~rx_empty;
                end
                OFF_COUNT:  rd_mux = {16'h0, 8'(tx_cnt), 8'(rx_cnt)};
`ifdef MAILBOX_IRQ_EN
                OFF_IRQEN:  rd_mux = {30'h0, irqen_q};
`endif
                default:    rd_mux = '0;
            endcase
        end
    end

    assign tx_pop  = tx_valid_o & tx_ready_i;
    assign tx_push = wr_op && (off_q == OFF_TXDATA);
    assign rx_push = rx_valid_i & rx_ready_o;
    assign rx_pop  = rd_op && (off_q == OFF_RXDATA) && !rx_empty;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (wr_op && off_q == OFF_STATUS) begin
            if (wdata_q[ST_OVF]) ovf_d = 1'b0;
            if (wdata_q[ST_UNF]) unf_d = 1'b0;
        end
        if (tx_push && tx_full && !tx_pop)                 ovf_d = 1'b1;
        if (rd_op && off_q == OFF_RXDATA && rx_empty)      unf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            rdata_q <= commit ? rd_mux : 32'h0;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign b_data_o   = rdata_q;
    assign tx_valid_o = ~tx_empty;
    assign rx_ready_o = ~rx_full;

`ifdef MAILBOX_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            irqen_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            if (wr_op && off_q == OFF_IRQEN) irqen_q <= wdata_q[1:0];
            irq_q <= (irqen_q[0] & ~rx_empty) | (irqen_q[1] & tx_empty);
        end
    end
    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (tx_push),
        .push_data_i (wdata_q),
        .pop_i       (tx_pop),
        .pop_data_o  (tx_data_o),
        .full_o      (tx_full),
        .empty_o     (tx_empty),
        .count_o     (tx_cnt)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rx_push),
        .push_data_i (rx_data_i),
        .pop_i       (rx_pop),
        .pop_data_o  (rx_head),
        .full_o      (rx_full),
        .empty_o     (rx_empty),
        .count_o     (rx_cnt)
    );

endmodule

// File: tb/tb_io_mailbox_responder.sv
// Bench for io_mailbox_responder: queue-based mailbox model, per-cycle output compare, directed + random bus traffic.
module tb_io_mailbox_responder;

    localparam int W = 1;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] b_addr_i, b_data_i, b_data_o, tx_data_o, rx_data_i;
    logic        b_read_i, b_write_i, b_ack_o, tx_valid_o, tx_ready_i;
    logic        rx_valid_i, rx_ready_o, irq_o;

    always #5 clk = ~clk;

    io_mailbox_responder #(.BASE_ADDR(20'h40000), .WAIT_STATES(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_read_i(b_read_i), .b_write_i(b_write_i),
        .b_data_o(b_data_o), .b_ack_o(b_ack_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .irq_o(irq_o)
    );

    logic [31:0] mq_tx[$];
    logic [31:0] mq_rx[$];
    bit          m_ovf, m_unf, m_irq;
    logic [1:0]  m_en;
    bit          exp_ack, exp_txv, exp_rxr, exp_irq;
    logic [31:0] exp_data, exp_txd;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 0;
    bit          agent_rand = 0;
    bit          ag_tx_rdy = 0, ag_rx_vld = 0;
    logic [31:0] ag_rx_dat = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model's view of the outputs after each edge.
    initial forever begin
        @(posedge clk);
        #2;
        if (chk_en) begin
            chk("b_ack_o",    32'(b_ack_o),    32'(exp_ack));
            chk("b_data_o",   b_data_o,        exp_data);
            chk("tx_valid_o", 32'(tx_valid_o), 32'(exp_txv));
            chk("rx_ready_o", 32'(rx_ready_o), 32'(exp_rxr));
            chk("irq_o",      32'(irq_o),      32'(exp_irq));
            if (exp_txv) chk("tx_data_o", tx_data_o, exp_txd);
        end
    end

    function automatic logic [31:0] model_read(input logic [9:0] off);
        case (off)
            10'h001: return (mq_rx.size() > 0) ? mq_rx[0] : 32'h0;
            10'h002: return {28'h0, m_ovf, m_unf, mq_tx.size() == D, mq_rx.size() > 0};
            10'h003: return {16'h0, 8'(mq_tx.size()), 8'(mq_rx.size())};
`ifdef MAILBOX_IRQ_EN
            10'h004: return {30'h0, m_en};
`endif
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle: choose agent inputs, predict the edge, advance to the next negedge.
    task automatic step(input bit rst_now, input bit commit, input bit wr, input bit rd,
                        input logic [9:0] off, input logic [31:0] wd);
        logic [31:0] rv;
        bit pop_tx, push_rx, irq_n;
        rst = rst_now;
        if (rst_now) begin
            tx_ready_i = 1'b0; rx_valid_i = 1'b0;
        end else if (agent_rand) begin
            tx_ready_i = 1'($urandom_range(0, 1));
            rx_valid_i = ($urandom_range(0, 2) == 0);
            rx_data_i  = $urandom;
        end else begin
            tx_ready_i = ag_tx_rdy; rx_valid_i = ag_rx_vld; rx_data_i = ag_rx_dat;
        end
        pop_tx  = tx_ready_i && (mq_tx.size() > 0);
        push_rx = rx_valid_i && (mq_rx.size() < D);
        irq_n   = (m_en[0] && mq_rx.size() > 0) || (m_en[1] && mq_tx.size() == 0);
        rv      = (commit && rd && !wr) ? model_read(off) : 32'h0;
        if (rst_now) begin
            mq_tx.delete(); mq_rx.delete();
            m_ovf = 0; m_unf = 0; m_en = 2'b00; irq_n = 0; rv = 0;
        end else begin
            if (pop_tx) void'(mq_tx.pop_front());
            if (commit && wr && off == 10'h000) begin
                if (mq_tx.size() < D) mq_tx.push_back(wd);
                else m_ovf = 1;
            end
            if (commit && rd && !wr && off == 10'h001) begin
                if (mq_rx.size() > 0) void'(mq_rx.pop_front());
                else m_unf = 1;
            end
            if (push_rx) mq_rx.push_back(rx_data_i);
            if (commit && wr && off == 10'h002) begin
                if (wd[3]) m_ovf = 0;
                if (wd[2]) m_unf = 0;
            end
`ifdef MAILBOX_IRQ_EN
            if (commit && wr && off == 10'h004) m_en = wd[1:0];
`endif
        end
        m_irq    = irq_n;
        exp_ack  = commit && !rst_now;
        exp_data = rv;
        exp_txv  = mq_tx.size() > 0;
        exp_txd  = exp_txv ? mq_tx[0] : 32'h0;
        exp_rxr  = mq_rx.size() < D;
        exp_irq  = m_irq;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 10'h0, 32'h0);
    endtask

    task automatic bus_op(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rdat);
        bit hit;
        hit = (wr || rd) && (addr[31:12] == 20'h40000);
        b_write_i = wr; b_read_i = rd; b_addr_i = addr; b_data_i = wd;
        rdat = 32'h0;
        if (!hit) begin
            idle(4);
        end else begin
            for (int i = 0; i < W; i++) begin
                step(0, 0, 0, 0, 10'h0, 32'h0);
                b_addr_i = $urandom; b_data_i = $urandom;
            end
            step(0, 1, wr, rd, addr[11:2], wd);
            rdat = b_data_o;
            step(0, 0, 0, 0, 10'h0, 32'h0);
        end
        b_write_i = 0; b_read_i = 0;
    endtask

    logic [31:0] r;
    logic [11:0] offs [7] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'hFF0};

    initial begin
        logic [31:0] a, d;
        int sel;
        b_addr_i = 0; b_data_i = 0; b_read_i = 0; b_write_i = 0;
        tx_ready_i = 0; rx_valid_i = 0; rx_data_i = 0; rst = 1;
        m_en = 2'b00;
        chk_en = 1;
        step(1, 0, 0, 0, 10'h0, 32'h0);
        step(1, 0, 0, 0, 10'h0, 32'h0);
        idle(2);

        bus_op(0, 1, 32'h40000008, 0, r); chk("reset_status", r, 32'h0);
        bus_op(0, 1, 32'h4000000C, 0, r); chk("reset_count", r, 32'h0);

        bus_op(1, 0, 32'h40000000, 32'hDEADBEEF, r);
        chk("t1_txvalid", 32'(tx_valid_o), 32'h1);
        chk("t1_txdata", tx_data_o, 32'hDEADBEEF);
        bus_op(0, 1, 32'h4000000C, 0, r); chk("t1_count", r, 32'h00000100);
        ag_tx_rdy = 1; idle(1); ag_tx_rdy = 0;

        ag_rx_vld = 1; ag_rx_dat = 32'h11; idle(1);
        ag_rx_dat = 32'h22; idle(1); ag_rx_vld = 0;
        bus_op(0, 1, 32'h40000004, 0, r); chk("t2_rx0", r, 32'h11);
        bus_op(0, 1, 32'h40000005, 0, r); chk("t2_rx1", r, 32'h22);
        bus_op(0, 1, 32'h40000004, 0, r); chk("t2_rx_empty", r, 32'h0);
        bus_op(0, 1, 32'h40000008, 0, r); chk("t2_status_unf", r, 32'h4);
        bus_op(1, 0, 32'h40000008, 32'h4, r);
        bus_op(0, 1, 32'h40000008, 0, r); chk("t2_status_clr", r, 32'h0);

        for (int i = 0; i < 9; i++) bus_op(1, 0, 32'h40000000, 32'h90000000 + i, r);
        bus_op(0, 1, 32'h4000000C, 0, r); chk("t3_count", r, 32'h00000800);
        bus_op(0, 1, 32'h40000008, 0, r); chk("t3_status_ovf", r, 32'h0000000A);
        ag_tx_rdy = 1; idle(8); ag_tx_rdy = 0;
        chk("t3_drained", 32'(tx_valid_o), 32'h0);
        bus_op(1, 0, 32'h40000008, 32'h8, r);

        bus_op(0, 1, 32'h40000FF0, 0, r); chk("t4_unmapped", r, 32'h0);
        bus_op(1, 0, 32'h40001000, 32'h5555AAAA, r);
        bus_op(0, 1, 32'h4000000C, 0, r); chk("t4_nohit_count", r, 32'h0);

        b_write_i = 1; b_addr_i = 32'h40000000; b_data_i = 32'hCAFE0001;
        step(0, 0, 0, 0, 10'h0, 32'h0);
        step(1, 0, 0, 0, 10'h0, 32'h0);
        b_write_i = 0;
        idle(4);
        chk("t5_abort_txvalid", 32'(tx_valid_o), 32'h0);
        bus_op(1, 0, 32'h40000000, 32'hCAFE0002, r);
        chk("t5_after_rst", tx_data_o, 32'hCAFE0002);
        ag_tx_rdy = 1; idle(1); ag_tx_rdy = 0;

`ifdef MAILBOX_IRQ_EN
        bus_op(1, 0, 32'h40000010, 32'h1, r);
        ag_rx_vld = 1; ag_rx_dat = 32'h77; idle(1); ag_rx_vld = 0;
        chk("t6_irq_lag", 32'(irq_o), 32'h0);
        idle(1);
        chk("t6_irq_set", 32'(irq_o), 32'h1);
        bus_op(0, 1, 32'h40000004, 0, r);
        idle(1);
        chk("t6_irq_clr", 32'(irq_o), 32'h0);
`endif

        agent_rand = 1;
        repeat (300) begin
            a = {20'h40000, offs[$urandom_range(0, 6)]};
            a[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a[31:12] = 20'h40001;
            d = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 4)       bus_op(0, 1, a, d, r);
            else if (sel < 8)  bus_op(1, 0, a, d, r);
            else if (sel == 8) bus_op(1, 1, a, d, r);
            else               bus_op(0, 0, a, d, r);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        agent_rand = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
